// File: rtl/mfcc_addr_pkg.sv
// Shared definitions for the MFCC framing address path: command codes for
// change_addr_15bits and the frame_addr_seq state encoding.
package mfcc_addr_pkg;

  localparam int ADDR_WIDTH = 15;

  localparam logic [1:0] ADDR_SEL_CLR  = 2'b00;
  localparam logic [1:0] ADDR_SEL_INC  = 2'b01;
  localparam logic [1:0] ADDR_SEL_ADD  = 2'b10;
  localparam logic [1:0] ADDR_SEL_HOLD = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CLR  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_EMIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_CLR  = ST_CLR,
    S_WAIT = ST_WAIT,
    S_EMIT = ST_EMIT,
    S_DONE = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/change_addr_15bits.sv
// 15-bit address-update unit: registers the command, then applies it to the
// address register, so a command is visible on change_addr_out two cycles later.
module change_addr_15bits
  import mfcc_addr_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            change_addr_sel,
  input  logic [ADDR_WIDTH-1:0] change_addr_value,
  output logic [ADDR_WIDTH-1:0] change_addr_out
);

  logic [1:0]            sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] value_q, value_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    sel_d   = change_addr_sel;
    value_d = change_addr_value;
    addr_d  = addr_q;
    case (sel_q)
      ADDR_SEL_CLR: addr_d = '0;
      ADDR_SEL_INC: addr_d = addr_q + ADDR_WIDTH'(1);
      ADDR_SEL_ADD: addr_d = addr_q + value_q;
      default:      addr_d = addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= ADDR_SEL_HOLD;
      value_q <= '0;
      addr_q  <= '0;
    end else begin
      sel_q   <= sel_d;
      value_q <= value_d;
      addr_q  <= addr_d;
    end
  end

  assign change_addr_out = addr_q;

endmodule

// File: rtl/frame_addr_seq.sv
// Drives change_addr_15bits to walk overlapping frames (N samples, base step H,
// F frames) and presents each settled address on a valid/ready port.
module frame_addr_seq #(
  parameter int ADDR_WIDTH = mfcc_addr_pkg::ADDR_WIDTH,
  parameter int NF_WIDTH   = 10,
  parameter int ADDR_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] frame_len,
  input  logic [ADDR_WIDTH-1:0] hop_len,
  input  logic [NF_WIDTH-1:0]   num_frames,
  output logic [1:0]            change_addr_sel,
  output logic [ADDR_WIDTH-1:0] change_addr_value,
  input  logic [ADDR_WIDTH-1:0] change_addr_out,
  output logic                  rd_addr_valid,
  input  logic                  rd_addr_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done
);
  import mfcc_addr_pkg::*;

  localparam logic [2:0] WAIT_INIT = 3'(ADDR_LAT - 1);

  seq_state_t            state_q, state_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic [NF_WIDTH-1:0]   f_q, f_d;
  logic [ADDR_WIDTH-1:0] rewind_q, rewind_d;
  logic [ADDR_WIDTH-1:0] sample_idx_q, sample_idx_d;
  logic [NF_WIDTH-1:0]   frame_idx_q, frame_idx_d;
  logic [2:0]            wait_cnt_q, wait_cnt_d;
  seq_state_t            after_cmd;

  // After any command, either wait out the unit's latency or sample next cycle.
  assign after_cmd = (ADDR_LAT == 1) ? S_EMIT : S_WAIT;

  always_comb begin
    state_d           = state_q;
    n_d               = n_q;
    f_d               = f_q;
    rewind_d          = rewind_q;
    sample_idx_d      = sample_idx_q;
    frame_idx_d       = frame_idx_q;
    wait_cnt_d        = wait_cnt_q;
    change_addr_sel   = ADDR_SEL_HOLD;
    change_addr_value = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (frame_len == '0 || num_frames == '0) begin
            state_d = S_DONE;
          end else begin
            n_d          = frame_len;
            f_d          = num_frames;
            rewind_d     = hop_len - frame_len + ADDR_WIDTH'(1);
            sample_idx_d = '0;
            frame_idx_d  = '0;
            state_d      = S_CLR;
          end
        end
      end
      S_CLR: begin
        change_addr_sel = ADDR_SEL_CLR;
        wait_cnt_d      = WAIT_INIT;
        state_d         = after_cmd;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q - 3'd1;
        if (wait_cnt_q <= 3'd1) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (rd_addr_ready) begin
          wait_cnt_d = WAIT_INIT;
          if (sample_idx_q != n_q - ADDR_WIDTH'(1)) begin
            change_addr_sel = ADDR_SEL_INC;
            sample_idx_d    = sample_idx_q + ADDR_WIDTH'(1);
            state_d         = after_cmd;
          end else if (frame_idx_q != f_q - NF_WIDTH'(1)) begin
            // Jump from the last sample of this frame to the next frame's base.
            change_addr_sel   = ADDR_SEL_ADD;
            change_addr_value = rewind_q;
            sample_idx_d      = '0;
            frame_idx_d       = frame_idx_q + NF_WIDTH'(1);
            state_d           = after_cmd;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      f_q          <= '0;
      rewind_q     <= '0;
      sample_idx_q <= '0;
      frame_idx_q  <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      f_q          <= f_d;
      rewind_q     <= rewind_d;
      sample_idx_q <= sample_idx_d;
      frame_idx_q  <= frame_idx_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign rd_addr_valid = (state_q == S_EMIT);
  assign rd_addr       = change_addr_out;
  assign busy          = (state_q == S_CLR) || (state_q == S_WAIT) || (state_q == S_EMIT);
  assign done          = (state_q == S_DONE);

endmodule
